// File: rtl/cmos_pixel_packer.sv
// OV5640 DVP capture front end: packs byte pairs into RGB565 words,
// drops settle frames after init, gates capture on FIFO room and checks frame geometry.
module cmos_pixel_packer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic        camera_pclk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        camera_vsync,
    input  logic        camera_href,
    input  logic [7:0]  camera_data,
    input  logic        fifo_ready,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        frame_complete,
    output logic        frame_ok,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 2);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 2);
    localparam int unsigned SKIP_W = $clog2(SKIP_FRAMES + 1) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_VS = 3'd1;
    localparam logic [2:0] S_SKIP    = 3'd2;
    localparam logic [2:0] S_ARM     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DROP    = 3'd5;

    logic              vs_r, vs_r_d, hr_r, hr_r_d;
    logic [7:0]        d_r;
    logic [2:0]        state, state_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_nxt;
    logic              phase, phase_nxt;
    logic [7:0]        hi_byte, hi_nxt;
    logic [PIX_W-1:0]  pix_cnt, pix_cnt_nxt;
    logic [LINE_W-1:0] line_cnt, line_cnt_nxt;
    logic              line_err, line_err_nxt;
    logic              pk_valid, pk_valid_nxt;
    logic [15:0]       pk_data, pk_data_nxt;
    logic [15:0]       pix_data_nxt;
    logic              pix_valid_nxt, frame_start_nxt, frame_complete_nxt, frame_ok_nxt;
    logic [7:0]        drop_nxt;
    logic              vs_rise_c, hr_fall_c;

    assign vs_rise_c = vs_r & ~vs_r_d;
    assign hr_fall_c = ~hr_r & hr_r_d;

    // State, pipeline and output registers
    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r           <= 1'b0;
            vs_r_d         <= 1'b0;
            hr_r           <= 1'b0;
            hr_r_d         <= 1'b0;
            d_r            <= 8'd0;
            state          <= S_IDLE;
            skip_cnt       <= '0;
            phase          <= 1'b0;
            hi_byte        <= 8'd0;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            line_err       <= 1'b0;
            pk_valid       <= 1'b0;
            pk_data        <= 16'd0;
            pix_data       <= 16'd0;
            pix_valid      <= 1'b0;
            frame_start    <= 1'b0;
            frame_complete <= 1'b0;
            frame_ok       <= 1'b0;
            drop_cnt       <= 8'd0;
        end else begin
            vs_r           <= camera_vsync;
            vs_r_d         <= vs_r;
            hr_r           <= camera_href;
            hr_r_d         <= hr_r;
            d_r            <= camera_data;
            state          <= state_nxt;
            skip_cnt       <= skip_nxt;
            phase          <= phase_nxt;
            hi_byte        <= hi_nxt;
            pix_cnt        <= pix_cnt_nxt;
            line_cnt       <= line_cnt_nxt;
            line_err       <= line_err_nxt;
            pk_valid       <= pk_valid_nxt;
            pk_data        <= pk_data_nxt;
            pix_data       <= pix_data_nxt;
            pix_valid      <= pix_valid_nxt;
            frame_start    <= frame_start_nxt;
            frame_complete <= frame_complete_nxt;
            frame_ok       <= frame_ok_nxt;
            drop_cnt       <= drop_nxt;
        end
    end

    // Next-state, packing and frame status logic
    always_comb begin
        state_nxt          = state;
        skip_nxt           = skip_cnt;
        phase_nxt          = phase;
        hi_nxt             = hi_byte;
        pix_cnt_nxt        = pix_cnt;
        line_cnt_nxt       = line_cnt;
        line_err_nxt       = line_err;
        pk_valid_nxt       = 1'b0;
        pk_data_nxt        = pk_data;
        pix_valid_nxt      = pk_valid;
        pix_data_nxt       = pk_valid ? pk_data : pix_data;
        frame_start_nxt    = 1'b0;
        frame_complete_nxt = 1'b0;
        frame_ok_nxt       = frame_ok;
        drop_nxt           = drop_cnt;

        case (state)
            S_IDLE: begin
                skip_nxt = '0;
                if (init_done) state_nxt = S_WAIT_VS;
            end
            S_WAIT_VS, S_SKIP: begin
                if (vs_rise_c) begin
                    if (skip_cnt < SKIP_W'(SKIP_FRAMES)) begin
                        state_nxt = S_SKIP;
                        skip_nxt  = skip_cnt + SKIP_W'(1);
                    end else begin
                        state_nxt = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (!vs_r) begin
                    if (fifo_ready) begin
                        state_nxt       = S_CAPTURE;
                        frame_start_nxt = 1'b1;
                    end else begin
                        state_nxt = S_DROP;
                        if (drop_cnt != 8'hFF) drop_nxt = drop_cnt + 8'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (hr_fall_c) begin
                    phase_nxt   = 1'b0;
                    pix_cnt_nxt = '0;
                    if (phase || (pix_cnt != PIX_W'(H_ACTIVE))) line_err_nxt = 1'b1;
                    if (line_cnt != LINE_W'(V_ACTIVE + 1)) line_cnt_nxt = line_cnt + LINE_W'(1);
                end else if (hr_r && !vs_rise_c) begin
                    if (!phase) begin
                        hi_nxt    = d_r;
                        phase_nxt = 1'b1;
                    end else begin
                        phase_nxt = 1'b0;
                        if (pix_cnt < PIX_W'(H_ACTIVE)) begin
                            pix_cnt_nxt  = pix_cnt + PIX_W'(1);
                            pk_valid_nxt = (line_cnt < LINE_W'(V_ACTIVE));
                            pk_data_nxt  = {hi_byte, d_r};
                        end else begin
                            pix_cnt_nxt = PIX_W'(H_ACTIVE + 1);
                        end
                    end
                end
                // Frame ends on vsync; a pending high byte is simply dropped
                if (vs_rise_c) begin
                    frame_complete_nxt = 1'b1;
                    frame_ok_nxt       = !line_err_nxt && (line_cnt_nxt == LINE_W'(V_ACTIVE));
                    state_nxt          = S_ARM;
                end
            end
            S_DROP: begin
                if (vs_rise_c) state_nxt = S_ARM;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (!init_done) begin
            state_nxt          = S_IDLE;
            skip_nxt           = '0;
            frame_complete_nxt = 1'b0;
            frame_ok_nxt       = frame_ok;
        end

        // Line/frame bookkeeping only lives inside a captured frame
        if (state_nxt != S_CAPTURE) begin
            phase_nxt    = 1'b0;
            pix_cnt_nxt  = '0;
            line_cnt_nxt = '0;
            line_err_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Randomized bench for cmos_pixel_packer against a frame-level reference model.
module tb_cmos_pixel_packer;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int SKIP = 2;

    logic        camera_pclk;
    logic        rst_n;
    logic        init_done;
    logic        camera_vsync;
    logic        camera_href;
    logic [7:0]  camera_data;
    logic        fifo_ready;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        frame_complete;
    logic        frame_ok;
    logic [7:0]  drop_cnt;

    cmos_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
        .camera_pclk    (camera_pclk),
        .rst_n          (rst_n),
        .init_done      (init_done),
        .camera_vsync   (camera_vsync),
        .camera_href    (camera_href),
        .camera_data    (camera_data),
        .fifo_ready     (fifo_ready),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .frame_start    (frame_start),
        .frame_complete (frame_complete),
        .frame_ok       (frame_ok),
        .drop_cnt       (drop_cnt)
    );

    initial camera_pclk = 1'b0;
    always #5 camera_pclk = ~camera_pclk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          vs_seen, cur_lines, exp_fs, exp_fc, exp_drop, exp_pix;
    bit          cur_cap, cur_bad;
    logic [15:0] exp_q[$];
    bit          ok_q[$];
    logic [7:0]  line_b[$];

    // observed state
    int          n_pix, n_fs, n_fc, cyc, mark_cyc, first_pv_cyc;
    bit          pv_armed;
    logic [15:0] first_pv_data, e_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge camera_pclk) cyc <= cyc + 1;

    always @(negedge camera_pclk) begin
        if (pix_valid) begin
            n_pix++;
            if (pv_armed) begin
                first_pv_cyc  = cyc;
                first_pv_data = pix_data;
                pv_armed      = 1'b0;
            end
            if (exp_q.size() == 0) chk("pix_unexpected", 32'(pix_valid), 32'd0);
            else begin
                e_pix = exp_q.pop_front();
                chk("pix_data", 32'(pix_data), 32'(e_pix));
            end
        end
        if (frame_start) begin
            n_fs++;
            pv_armed = 1'b1;
        end
        if (frame_complete) begin
            n_fc++;
            if (ok_q.size() == 0) chk("fc_unexpected", 32'(frame_complete), 32'd0);
            else chk("frame_ok", 32'(frame_ok), 32'(ok_q.pop_front()));
        end
    end

    // A vsync closes the current frame and decides the fate of the next one
    task automatic model_vsync(input bit fr);
        if (cur_cap) begin
            ok_q.push_back(cur_lines == V && !cur_bad);
            exp_fc++;
        end
        cur_cap = 0; cur_lines = 0; cur_bad = 0;
        if (vs_seen < SKIP) vs_seen++;
        else if (fr) begin cur_cap = 1; exp_fs++; end
        else if (exp_drop < 255) exp_drop++;
    endtask

    task automatic model_line();
        if (cur_cap) begin
            for (int p = 0; p < line_b.size() / 2; p++)
                if (cur_lines < V && p < H) begin
                    exp_q.push_back({line_b[2*p], line_b[2*p+1]});
                    exp_pix++;
                end
            if (line_b.size() != 2 * H) cur_bad = 1;
            cur_lines++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete(); ok_q.delete();
        vs_seen = 0; cur_cap = 0; cur_lines = 0; cur_bad = 0;
        exp_fs = 0; exp_fc = 0; exp_drop = 0; exp_pix = 0;
        n_pix = 0; n_fs = 0; n_fc = 0;
    endtask

    task automatic vs_pulse(input bit fr);
        fifo_ready = fr;
        model_vsync(fr);
        @(posedge camera_pclk); #1 camera_vsync = 1'b1;
        repeat (3) @(posedge camera_pclk);
        #1 camera_vsync = 1'b0;
        repeat (6) @(posedge camera_pclk);
    endtask

    task automatic drive_line(input int nbytes, input bit mark);
        line_b.delete();
        for (int i = 0; i < nbytes; i++) line_b.push_back(8'($urandom));
        if (mark) begin line_b[0] = 8'hF8; line_b[1] = 8'h1F; end
        model_line();
        for (int i = 0; i < nbytes; i++) begin
            @(posedge camera_pclk); #1;
            camera_href = 1'b1;
            camera_data = line_b[i];
            if (mark && i == 1) mark_cyc = cyc;
        end
        @(posedge camera_pclk); #1;
        camera_href = 1'b0;
        camera_data = 8'($urandom);
        repeat (4) @(posedge camera_pclk);
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_npix"}, 32'(n_pix), 32'(exp_pix));
        chk({tag, "_nfs"}, 32'(n_fs), 32'(exp_fs));
        chk({tag, "_nfc"}, 32'(n_fc), 32'(exp_fc));
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic send_frame(input bit fr, input int nl, input int bad_line,
                              input int bad_bytes, input bit mark, input string tag);
        vs_pulse(fr);
        for (int l = 0; l < nl; l++)
            drive_line((l == bad_line) ? bad_bytes : 2 * H, mark && l == 0);
        end_check(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
        chk({tag, "_fcomp"}, 32'(frame_complete), 32'd0);
        chk({tag, "_fok"}, 32'(frame_ok), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; pv_armed = 0; mark_cyc = 0; first_pv_cyc = 0; first_pv_data = 0;
        model_reset();
        rst_n = 1'b0; init_done = 1'b0; camera_vsync = 1'b0; camera_href = 1'b0;
        camera_data = 8'd0; fifo_ready = 1'b1;
        repeat (3) @(posedge camera_pclk);
        #2 chk_all_zero("rst");
        rst_n = 1'b1;
        repeat (3) @(posedge camera_pclk);
        #1 init_done = 1'b1;
        repeat (5) @(posedge camera_pclk);

        // two settle frames, then two clean captured frames
        send_frame(1, V, -1, 0, 0, "skip1");
        send_frame(1, V, -1, 0, 0, "skip2");
        send_frame(1, V, -1, 0, 1, "cap1");
        chk("lat", 32'(first_pv_cyc - mark_cyc), 32'd3);
        chk("f81f", 32'(first_pv_data), 32'h0000F81F);
        send_frame(1, V, -1, 0, 0, "cap2");

        // no FIFO room: three dropped frames, then capture resumes
        send_frame(0, V, -1, 0, 0, "drop1");
        send_frame(0, V, -1, 0, 0, "drop2");
        send_frame(0, V, -1, 0, 0, "drop3");
        chk("drop3", 32'(drop_cnt), 32'd3);
        send_frame(1, V, -1, 0, 0, "resume");

        // odd-length line, then a clean frame
        send_frame(1, V, 1, 15, 0, "oddline");
        send_frame(1, V, -1, 0, 0, "afterodd");
        chk("ok_odd", 32'(frame_ok), 32'd0);
        send_frame(1, 3, -1, 0, 0, "short");
        send_frame(1, V, -1, 0, 0, "aftershort");
        chk("ok_short", 32'(frame_ok), 32'd0);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            bit fr;
            int nl;
            fr = ($urandom_range(0, 3) != 0);
            nl = $urandom_range(3, 5);
            vs_pulse(fr);
            for (int l = 0; l < nl; l++)
                drive_line(($urandom_range(0, 3) == 0) ? $urandom_range(10, 20) : 2 * H, 0);
            end_check("rnd");
        end

        // reset mid-line of a captured frame
        vs_pulse(1);
        line_b.delete();
        for (int i = 0; i < 6; i++) line_b.push_back(8'($urandom));
        model_line();
        for (int i = 0; i < 6; i++) begin
            @(posedge camera_pclk); #1;
            camera_href = 1'b1;
            camera_data = line_b[i];
        end
        @(posedge camera_pclk); #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        camera_href = 1'b0;
        model_reset();
        repeat (3) @(posedge camera_pclk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge camera_pclk);
        send_frame(1, V, -1, 0, 0, "rskip1");
        send_frame(1, V, -1, 0, 0, "rskip2");
        send_frame(1, V, -1, 0, 0, "rcap");
        vs_pulse(1);
        end_check("rend");
        chk("ok_after_rst", 32'(frame_ok), 32'd1);
        repeat (5) @(posedge camera_pclk);
        chk("q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
